// File: rtl/stream_demux_pkg.sv
// Shared constants, helpers and types for the stream_demux block.
package stream_demux_pkg;

  // Largest supported channel count.
  localparam int unsigned MAX_CH = 16;

  // Width of an index able to address any of MAX_CH channels.
  localparam int unsigned CH_IDX_W = 4;

  // Channel index wide enough for the largest configuration.
  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // ceil(log2(n)), never less than 1; used to size select fields.
  function automatic int unsigned sel_w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel.
// A load always wins over a pop so a drained slot can refill in the same cycle.
module stream_demux_slot #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic [DW-1:0] dout
);

  // Full flag and payload; data is kept (not cleared) when the beat is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with valid/ready on every side.
// Optional broadcast mode is enabled by defining STREAM_DEMUX_BCAST_EN,
// which adds the in_bcast port and loads every channel from one beat.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned SW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_valid,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic              in_bcast,
`endif
  output logic              in_ready,
  output logic [N_CH*DW-1:0] out_data,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic              err_sel
);

  logic            bcast;
  logic            sel_ok;
  logic            hs_in;
  logic [N_CH-1:0] sel_hit;
  logic [N_CH-1:0] slot_free;
  logic [N_CH-1:0] load;
  logic [N_CH-1:0] pop;

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Select decode: one-hot channel hit, empty when the select is out of range.
  always_comb begin
    sel_hit = '0;
    sel_ok  = (32'(in_sel) < N_CH);
    for (int unsigned k = 0; k < N_CH; k++) begin
      sel_hit[k] = sel_ok && (32'(in_sel) == k);
    end
  end

  // A slot can take a new beat when empty or when its current beat leaves now.
  assign slot_free = ~out_valid | out_ready;
  assign pop       = out_valid & out_ready;

  // Input ready: bad selects are always sunk; broadcast needs every slot free.
  always_comb begin
    in_ready = 1'b1;
    if (bcast) begin
      in_ready = &slot_free;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & slot_free);
    end
  end

  assign hs_in = in_valid & in_ready;

  // Per-slot load strobes for the accepted beat.
  always_comb begin
    load = '0;
    if (hs_in) begin
      load = bcast ? '1 : sel_hit;
    end
  end

  // One-cycle pulse after a dropped out-of-range beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sel <= 1'b0;
    end else begin
      err_sel <= hs_in & ~sel_ok & ~bcast;
    end
  end

  // One output register per channel.
  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    stream_demux_slot #(
      .DW(DW)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .pop  (pop[k]),
      .din  (in_data),
      .full (out_valid[k]),
      .dout (out_data[k*DW +: DW])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux (5 channels, 3-bit select so
// selects 5..7 exercise the drop path on a non-power-of-two build).
module tb_stream_demux;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic            in_valid;
  logic            in_bcast;
  logic            in_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic            err_sel;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  stream_demux #(
    .N_CH(N),
    .DW  (DW),
    .SW  (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast (in_bcast),
`endif
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_sel  (err_sel)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            mf [N];
  logic [DW-1:0] md [N];
  bit            merr;
  bit            live = 1'b0;
  bit            stalled = 1'b0;
  logic [SW-1:0] st_sel;
  logic [DW-1:0] st_data;

  function automatic bit m_ready();
    bit r;
    r = 1'b1;
    if (in_bcast) begin
      for (int k = 0; k < N; k++) if (mf[k] && !out_ready[k]) r = 1'b0;
    end else if (in_sel < N) begin
      r = !mf[in_sel] || out_ready[in_sel];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    bit rdy, hs, ok;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        mf[k] = 1'b0;
        md[k] = '0;
      end
      merr    = 1'b0;
      live    = 1'b1;
      stalled = 1'b0;
    end else if (live) begin
      if (stalled && in_valid)
        chk("in_stable", 64'({in_sel, in_data}), 64'({st_sel, st_data}));
      rdy = m_ready();
      hs  = in_valid && rdy;
      ok  = (in_sel < N);
      for (int k = 0; k < N; k++) if (mf[k] && out_ready[k]) mf[k] = 1'b0;
      if (hs && in_bcast) begin
        for (int k = 0; k < N; k++) begin
          mf[k] = 1'b1;
          md[k] = in_data;
        end
      end else if (hs && ok) begin
        mf[in_sel] = 1'b1;
        md[in_sel] = in_data;
      end
      merr    = hs && !ok && !in_bcast;
      stalled = in_valid && !rdy;
      st_sel  = in_sel;
      st_data = in_data;
    end
  end

  // Compare DUT against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    if (live && !rst) begin
      for (int k = 0; k < N; k++) begin
        ev[k]            = mf[k];
        ed[k*DW +: DW]   = md[k];
      end
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_data", 64'(out_data), 64'(ed));
      chk("err_sel", 64'(err_sel), 64'(merr));
      chk("in_ready", 64'(in_ready), 64'(m_ready()));
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int sel, input logic [DW-1:0] d, input int max_wait);
    bit took;
    int n;
    in_sel   = SW'(sel);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) break;
      n++;
      if (n > max_wait) begin
        chk("send_timeout", 64'(0), 64'(1));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] oh;
    int start;

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0;
    in_bcast = 1'b0; out_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_err", 64'(err_sel), 64'(0));

    // Beats to channels 0..3, all consumers ready.
    for (int i = 0; i < 4; i++) begin
      send(i, DW'(8'hA0 + i), 20);
      oh = '0;
      oh[i] = 1'b1;
      chk("t1_valid", 64'(out_valid), 64'(oh));
      chk("t1_data", 64'(out_data[i*DW +: DW]), 64'(8'hA0 + i));
      chk("t1_ready", 64'(in_ready), 64'(1));
    end
    idle(2);

    // Stalled channel 2 does not block channel 1; pass-through refill.
    out_ready = 5'b11011;
    send(2, 8'h55, 20);
    chk("t2_full", 64'(out_valid[2]), 64'(1));
    chk("t2_data", 64'(out_data[2*DW +: DW]), 64'(8'h55));
    in_sel = 3'd2;
    @(negedge clk);
    chk("t2_blocked", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    send(1, 8'h11, 20);
    chk("t2_ch1", 64'(out_data[1*DW +: DW]), 64'(8'h11));
    fork
      send(2, 8'h77, 20);
      begin
        @(negedge clk);
        chk("t2_stall", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        out_ready[2] = 1'b1;
      end
    join
    chk("t2_refill_v", 64'(out_valid[2]), 64'(1));
    chk("t2_refill_d", 64'(out_data[2*DW +: DW]), 64'(8'h77));
    idle(2);

    // Out-of-range selects are sunk with a one-cycle error pulse.
    send(5, 8'h5A, 20);
    chk("t3_err5", 64'(err_sel), 64'(1));
    chk("t3_nov5", 64'(out_valid), 64'(0));
    idle(1);
    chk("t3_err_clr", 64'(err_sel), 64'(0));
    send(7, 8'h7E, 20);
    chk("t3_err7", 64'(err_sel), 64'(1));
    idle(1);
    chk("t3_err_clr7", 64'(err_sel), 64'(0));

    // Eight back-to-back beats to channel 0, one per cycle.
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      send(0, DW'(8'hB0 + i), 20);
      chk("t4_data", 64'(out_data[DW-1:0]), 64'(8'hB0 + i));
    end
    chk("t4_cycles", 64'(cyc - start), 64'(8));
    idle(2);

    // Reset discards a held beat.
    out_ready[1] = 1'b0;
    send(1, 8'hC1, 20);
    chk("t5_held", 64'(out_valid[1]), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'(0));
    chk("t5_data", 64'(out_data), 64'(0));
    chk("t5_err", 64'(err_sel), 64'(0));
    out_ready = '1;
    idle(2);
    chk("t5_lost", 64'(out_valid), 64'(0));

`ifdef STREAM_DEMUX_BCAST_EN
    // Broadcast waits for every slot, then fills all channels.
    out_ready[3] = 1'b0;
    send(3, 8'h33, 20);
    in_bcast = 1'b1;
    fork
      send(6, 8'hA5, 20);
      begin
        @(negedge clk);
        chk("t6_blocked", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        out_ready[3] = 1'b1;
      end
    join
    in_bcast = 1'b0;
    chk("t6_valid", 64'(out_valid), 64'({N{1'b1}}));
    for (int k = 0; k < N; k++)
      chk("t6_data", 64'(out_data[k*DW +: DW]), 64'(8'hA5));
    chk("t6_noerr", 64'(err_sel), 64'(0));
    idle(2);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
